// File: rtl/pa_soc_itcm_pipe_if.sv
// Fetch (req/gnt, rvalid/rready) and load-port bundle of the instruction TCM.
interface pa_soc_itcm_pipe_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    fetch_req;
    logic [ADDR_WIDTH-1:0]   fetch_addr;
    logic                    fetch_gnt;
    logic                    fetch_rvalid;
    logic                    fetch_rready;
    logic [DATA_WIDTH-1:0]   fetch_rdata;
    logic                    fetch_unalign;
    logic                    fetch_range;
    logic                    load_we;
    logic [ADDR_WIDTH-1:0]   load_addr;
    logic [DATA_WIDTH/8-1:0] load_be;
    logic [DATA_WIDTH-1:0]   load_data;

    modport slave (
        input  fetch_req, fetch_addr, fetch_rready,
        input  load_we, load_addr, load_be, load_data,
        output fetch_gnt, fetch_rvalid, fetch_rdata, fetch_unalign, fetch_range
    );

    modport master (
        output fetch_req, fetch_addr, fetch_rready,
        output load_we, load_addr, load_be, load_data,
        input  fetch_gnt, fetch_rvalid, fetch_rdata, fetch_unalign, fetch_range
    );
endinterface

// File: rtl/pa_soc_itcm_pipe.sv
// Instruction TCM: registered read port, optional output register stage,
// rvalid/rready backpressure, byte-enabled load port with priority over fetch.
module pa_soc_itcm_pipe #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    SIZE_KB    = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter bit                    OUT_REG    = 1'b0
) (
    input logic clk_i,
    input logic rst_n_i,
    pa_soc_itcm_pipe_if.slave bus
);
    localparam int NB   = DATA_WIDTH / 8;
    localparam int LSB  = $clog2(NB);
    localparam int NW   = SIZE_KB * 1024 / NB;
    localparam int WIDX = $clog2(NW);
    localparam logic [ADDR_WIDTH-1:0] SIZE_BYTES = ADDR_WIDTH'(SIZE_KB * 1024);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  unalign;
        logic                  rng;
    } rsp_t;

    logic [DATA_WIDTH-1:0] mem [NW];

    logic [ADDR_WIDTH-1:0] f_off, l_off;
    logic [WIDX-1:0]       f_idx, l_idx;
    logic                  f_unalign, f_range, l_ok;
    logic                  accept, s1_adv, s1_vld;
    rsp_t                  s1;

    assign f_off     = bus.fetch_addr - BASE_ADDR;
    assign f_idx     = f_off[LSB +: WIDX];
    assign f_unalign = |bus.fetch_addr[LSB-1:0];
    assign f_range   = f_off >= SIZE_BYTES;

    assign l_off = bus.load_addr - BASE_ADDR;
    assign l_idx = l_off[LSB +: WIDX];
    assign l_ok  = bus.load_we && (l_off < SIZE_BYTES);

    // Low offset bits select bytes within a word and carry no index information.
    logic unused_bits;
    assign unused_bits = ^{f_off[LSB-1:0], l_off[LSB-1:0]};

    // Load cycles block fetch so a read never observes a half-written word.
    assign bus.fetch_gnt = !bus.load_we && (!s1_vld || s1_adv);
    assign accept        = bus.fetch_req && bus.fetch_gnt;

    always_ff @(posedge clk_i) begin
        if (l_ok) begin
            for (int b = 0; b < NB; b++) begin
                if (bus.load_be[b]) mem[l_idx][8*b +: 8] <= bus.load_data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_vld <= 1'b0;
            s1     <= '0;
        end else if (accept) begin
            s1_vld     <= 1'b1;
            s1.unalign <= f_unalign;
            s1.rng     <= !f_unalign && f_range;
            s1.data    <= (f_unalign || f_range) ? '0 : mem[f_idx];
        end else if (s1_adv) begin
            s1_vld <= 1'b0;
        end
    end

    generate
        if (OUT_REG) begin : g_oreg
            logic s2_vld, s2_load;
            rsp_t s2;

            assign s2_load = !s2_vld || bus.fetch_rready;
            assign s1_adv  = s1_vld && s2_load;

            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    s2_vld <= 1'b0;
                    s2     <= '0;
                end else if (s2_load) begin
                    s2_vld <= s1_vld;
                    if (s1_vld) s2 <= s1;
                end
            end

            assign bus.fetch_rvalid  = s2_vld;
            assign bus.fetch_rdata   = s2.data;
            assign bus.fetch_unalign = s2.unalign;
            assign bus.fetch_range   = s2.rng;
        end else begin : g_direct
            assign s1_adv            = s1_vld && bus.fetch_rready;
            assign bus.fetch_rvalid  = s1_vld;
            assign bus.fetch_rdata   = s1.data;
            assign bus.fetch_unalign = s1.unalign;
            assign bus.fetch_range   = s1.rng;
        end
    endgenerate
endmodule

// File: tb/tb_pa_soc_itcm_pipe.sv
// Scoreboard bench for pa_soc_itcm_pipe: table-driven fetches plus hand sequences.
module tb_pa_soc_itcm_pipe;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SKB  = 16;
    localparam int OREG = 1;

    localparam logic [31:0] W0 = 32'h00010203;
    localparam logic [31:0] W1 = 32'h04050607;
    localparam logic [31:0] W2 = 32'h08090A0B;
    localparam logic [31:0] W3 = 32'h0C0D0E0F;
    localparam logic [31:0] WL = 32'hCAFEF00D;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    pa_soc_itcm_pipe_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    pa_soc_itcm_pipe #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SIZE_KB(SKB),
        .BASE_ADDR(32'h0), .OUT_REG(OREG)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        un;
        logic        rg;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        un;
        logic        rg;
    } vec_t;

    exp_t sbq[$];
    vec_t vecs[9];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   n_acc = 0;
    bit   chk_lat = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Front of the scoreboard must be on the outputs whenever rvalid is high,
    // including every held cycle under backpressure.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.fetch_rvalid) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL spurious_rsp: got rdata %0h with nothing outstanding", bus.fetch_rdata);
            end else begin
                e = sbq[0];
                check("rsp", {30'd0, bus.fetch_rdata, bus.fetch_unalign, bus.fetch_range},
                      {30'd0, e.data, e.un, e.rg});
                if (bus.fetch_rready) begin
                    if (chk_lat) check("latency", 64'(cyc - e.cyc), 64'(1 + OREG));
                    void'(sbq.pop_front());
                end
            end
        end
    end

    // Called at #1 after a rising edge; returns at #1 after the write edge.
    task automatic load(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        bus.load_we   = 1'b1;
        bus.load_addr = a;
        bus.load_be   = be;
        bus.load_data = d;
        @(posedge clk);
        #1;
        bus.load_we = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] d, input logic un, input logic rg);
        exp_t e;
        bit   ok;
        ok = 1'b0;
        e.data = d;
        e.un   = un;
        e.rg   = rg;
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = a;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (bus.fetch_gnt) begin
                e.cyc = cyc;
                sbq.push_back(e);
                n_acc++;
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        bus.fetch_req = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL gnt_timeout: addr %0h never granted", a);
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && sbq.size() != 0; i++) @(posedge clk);
        #1;
        check(name, 64'(sbq.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int stale;
        vecs[0] = '{32'h0000_0000, W0, 1'b0, 1'b0};
        vecs[1] = '{32'h0000_0004, W1, 1'b0, 1'b0};
        vecs[2] = '{32'h0000_0008, W2, 1'b0, 1'b0};
        vecs[3] = '{32'h0000_000C, W3, 1'b0, 1'b0};
        vecs[4] = '{32'h0000_3FFC, WL, 1'b0, 1'b0};
        vecs[5] = '{32'h0000_0002, 32'h0, 1'b1, 1'b0};
        vecs[6] = '{32'h0000_4000, 32'h0, 1'b0, 1'b1};
        vecs[7] = '{32'h0000_4002, 32'h0, 1'b1, 1'b0};
        vecs[8] = '{32'hFFFF_FFFC, 32'h0, 1'b0, 1'b1};

        bus.fetch_req    = 1'b0;
        bus.fetch_addr   = '0;
        bus.fetch_rready = 1'b1;
        bus.load_we      = 1'b0;
        bus.load_addr    = '0;
        bus.load_be      = '0;
        bus.load_data    = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_rvalid", 64'(bus.fetch_rvalid), 64'd0);
        check("reset_rdata", 64'(bus.fetch_rdata), 64'd0);
        check("reset_flags", 64'({bus.fetch_unalign, bus.fetch_range}), 64'd0);
        check("reset_gnt_no_req", 64'(bus.fetch_gnt), 64'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        load(32'h00, 4'hF, W0);
        load(32'h04, 4'hF, W1);
        load(32'h08, 4'hF, W2);
        load(32'h0C, 4'hF, W3);
        load(32'h3FFC, 4'hF, WL);

        // Back-to-back table with rready held high: one accept per cycle, fixed latency.
        chk_lat = 1'b1;
        foreach (vecs[i]) fetch(vecs[i].addr, vecs[i].data, vecs[i].un, vecs[i].rg);
        drain("drain_table");
        chk_lat = 1'b0;

        // Backpressure: three requests against a stalled consumer.
        n_acc = 0;
        bus.fetch_rready = 1'b0;
        fork
            begin
                fetch(32'h00, W0, 1'b0, 1'b0);
                fetch(32'h04, W1, 1'b0, 1'b0);
                fetch(32'h08, W2, 1'b0, 1'b0);
            end
            begin
                repeat (5) @(negedge clk);
                check("bp_accepts", 64'(n_acc), 64'(1 + OREG));
                check("bp_gnt_low", 64'(bus.fetch_gnt), 64'd0);
                @(posedge clk);
                #1;
                bus.fetch_rready = 1'b1;
            end
        join
        drain("drain_bp");
        check("bp_total", 64'(n_acc), 64'd3);

        // Load and fetch in the same cycle: load wins, fetch follows with new data.
        bus.load_we      = 1'b1;
        bus.load_addr    = 32'h10;
        bus.load_be      = 4'hF;
        bus.load_data    = 32'h5A5A_0001;
        bus.fetch_req    = 1'b1;
        bus.fetch_addr   = 32'h10;
        @(negedge clk);
        check("load_blocks_gnt", 64'(bus.fetch_gnt), 64'd0);
        @(posedge clk);
        #1;
        bus.load_we = 1'b0;
        fetch(32'h10, 32'h5A5A_0001, 1'b0, 1'b0);

        // Partial write on lane 2 (bits 23:16).
        load(32'h14, 4'hF, 32'h1122_3344);
        load(32'h14, 4'b0100, 32'hAABB_CCDD);
        fetch(32'h14, 32'h11BB_3344, 1'b0, 1'b0);

        // Out-of-range load must not alias onto word 0.
        load(32'h4000, 4'hF, 32'hDEAD_BEEF);
        fetch(32'h00, W0, 1'b0, 1'b0);
        drain("drain_misc");

        // Reset with two responses held in the pipeline.
        bus.fetch_rready = 1'b0;
        fetch(32'h04, W1, 1'b0, 1'b0);
        fetch(32'h08, W2, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_rvalid", 64'(bus.fetch_rvalid), 64'd0);
        check("midrst_rdata", 64'(bus.fetch_rdata), 64'd0);
        sbq.delete();
        bus.fetch_rready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.fetch_rvalid) stale++;
        end
        check("no_stale_rsp", 64'(stale), 64'd0);

        // Pipeline still works after reset.
        @(posedge clk);
        #1;
        chk_lat = 1'b1;
        fetch(32'h0C, W3, 1'b0, 1'b0);
        drain("drain_post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
